// File: rtl/uart_match_arbiter.sv
// Round-robin arbiter that merges per-channel pattern-match pulses into one
// valid/ready event stream, with saturating pending counts and error flush.
module uart_match_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] match_i,
   input  logic              frame_done_i,
   input  logic              framing_error_i,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [2:0]        evt_ch,
   output logic [NUM_CH-1:0] overflow,
   output logic              err_flush,
   output logic [15:0]       delivered_cnt
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] pend_nz;
   logic [NUM_CH-1:0] overflow_q;
   logic [2:0]        last_grant_q;
   logic [2:0]        evt_ch_q;
   logic              err_flush_q;
   logic [15:0]       delivered_q;
   logic [2:0]        grant;
   logic              grant_found;
   logic              flush;
   logic              xfer;
   logic              load;

   assign flush = frame_done_i & framing_error_i;
   assign xfer  = (state_q == PRESENT) & evt_ready;
   // A flush cycle never loads a grant, even if the held event completes.
   assign load  = !flush && ((state_q == IDLE) || xfer) && grant_found;

   // Search starts one past the last grant and wraps at NUM_CH.
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_found = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(last_grant_q) + k) % NUM_CH;
         if (!grant_found && pend_nz[IDX_W'(idx)]) begin
            grant       = 3'(idx);
            grant_found = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_pend
         logic [CNT_W-1:0] pend_q;
         logic             ovf_q;
         logic             dec;
         logic             sat_drop;

         assign dec      = load && (grant == 3'(gi));
         assign sat_drop = match_i[gi] && !dec && (pend_q == PEND_MAX);

         always_ff @(posedge clk) begin
            if (rst) begin
               pend_q <= '0;
               ovf_q  <= 1'b0;
            end else if (flush) begin
               pend_q <= '0;
            end else begin
               if (match_i[gi] && !dec && !sat_drop)
                  pend_q <= pend_q + 1'b1;
               else if (!match_i[gi] && dec)
                  pend_q <= pend_q - 1'b1;
               if (sat_drop)
                  ovf_q <= 1'b1;
            end
         end

         assign pend_nz[gi]    = (pend_q != '0);
         assign overflow_q[gi] = ovf_q;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = PRESENT;
         PRESENT: if (xfer && !load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      evt_valid = (state_q == PRESENT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_ch_q     <= '0;
         last_grant_q <= 3'(NUM_CH - 1);
         err_flush_q  <= 1'b0;
         delivered_q  <= '0;
      end else begin
         err_flush_q <= flush;
         if (load) begin
            evt_ch_q     <= grant;
            last_grant_q <= grant;
         end
         if (xfer)
            delivered_q <= delivered_q + 16'd1;
      end
   end

   assign evt_ch        = evt_ch_q;
   assign overflow      = overflow_q;
   assign err_flush     = err_flush_q;
   assign delivered_cnt = delivered_q;

endmodule

// File: tb/tb_uart_match_arbiter.sv
// Directed bench for uart_match_arbiter: latency, round-robin order,
// saturation, error flush, grant/match collision and mid-stream reset.
module tb_uart_match_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] match_i;
   logic       frame_done_i;
   logic       framing_error_i;
   logic       evt_ready;
   logic       evt_valid;
   logic [2:0] evt_ch;
   logic [3:0] overflow;
   logic       err_flush;
   logic [15:0] delivered_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_match_arbiter #(.NUM_CH(4), .CNT_W(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .match_i         (match_i),
      .frame_done_i    (frame_done_i),
      .framing_error_i (framing_error_i),
      .evt_ready       (evt_ready),
      .evt_valid       (evt_valid),
      .evt_ch          (evt_ch),
      .overflow        (overflow),
      .err_flush       (err_flush),
      .delivered_cnt   (delivered_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Apply inputs for one clock, then observe 1ns after the edge.
   task automatic step(input logic [3:0] m, input logic fd, input logic fe);
      match_i         = m;
      frame_done_i    = fd;
      framing_error_i = fe;
      @(posedge clk);
      #1;
      match_i         = '0;
      frame_done_i    = 1'b0;
      framing_error_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   int xfers;
   int bad_ch;

   initial begin
      rst             = 1'b1;
      match_i         = '0;
      frame_done_i    = 1'b0;
      framing_error_i = 1'b0;
      evt_ready       = 1'b0;
      do_reset();

      // Reset state
      check_val("rst_valid", 32'(evt_valid), 32'd0);
      check_val("rst_ch", 32'(evt_ch), 32'd0);
      check_val("rst_ovf", 32'(overflow), 32'd0);
      check_val("rst_flush", 32'(err_flush), 32'd0);
      check_val("rst_deliv", 32'(delivered_cnt), 32'd0);

      // Single event: two-edge latency, one-cycle valid
      evt_ready = 1'b1;
      step(4'b0100, 1'b0, 1'b0);
      check_val("single_t1_valid", 32'(evt_valid), 32'd0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("single_t2_valid", 32'(evt_valid), 32'd1);
      check_val("single_t2_ch", 32'(evt_ch), 32'd2);
      step(4'b0000, 1'b0, 1'b0);
      check_val("single_after_valid", 32'(evt_valid), 32'd0);
      check_val("single_deliv", 32'(delivered_cnt), 32'd1);
      check_val("single_ovf", 32'(overflow), 32'd0);

      // Round-robin from reset pointer: 0,1,3
      do_reset();
      evt_ready = 1'b1;
      step(4'b1011, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_a_ch0", 32'(evt_ch), 32'd0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_a_ch1", 32'(evt_ch), 32'd1);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_a_ch3", 32'(evt_ch), 32'd3);
      check_val("rr_a_valid3", 32'(evt_valid), 32'd1);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_a_idle", 32'(evt_valid), 32'd0);
      // Pointer at 3: 1001 gives 0 then 3
      step(4'b1001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_b_first", 32'(evt_ch), 32'd0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_b_second", 32'(evt_ch), 32'd3);
      step(4'b0000, 1'b0, 1'b0);
      // Move pointer to 1, then 1001 gives 3 then 0
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_c_ch1", 32'(evt_ch), 32'd1);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b1001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_d_first", 32'(evt_ch), 32'd3);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_d_second", 32'(evt_ch), 32'd0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("rr_idle", 32'(evt_valid), 32'd0);
      check_val("rr_deliv", 32'(delivered_cnt), 32'd8);

      // Saturation on channel 1 with ready low
      do_reset();
      evt_ready = 1'b0;
      for (int i = 0; i < 16; i++) step(4'b0010, 1'b0, 1'b0);
      check_val("sat_ovf_before", 32'(overflow), 32'd0);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("sat_ovf", 32'(overflow), 32'h2);
      check_val("sat_held_valid", 32'(evt_valid), 32'd1);
      check_val("sat_held_ch", 32'(evt_ch), 32'd1);
      evt_ready = 1'b1;
      xfers  = 0;
      bad_ch = 0;
      for (int i = 0; i < 24; i++) begin
         if (evt_valid) begin
            xfers++;
            if (evt_ch != 3'd1) bad_ch++;
         end
         step(4'b0000, 1'b0, 1'b0);
      end
      check_val("sat_xfers", 32'(xfers), 32'd16);
      check_val("sat_bad_ch", 32'(bad_ch), 32'd0);
      check_val("sat_deliv", 32'(delivered_cnt), 32'd16);
      check_val("sat_drained", 32'(evt_valid), 32'd0);
      check_val("sat_ovf_sticky", 32'(overflow), 32'h2);

      // Error flush with an event held in the output register
      do_reset();
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
      step(4'b0100, 1'b1, 1'b1);
      check_val("flush_pulse", 32'(err_flush), 32'd1);
      check_val("flush_held_valid", 32'(evt_valid), 32'd1);
      check_val("flush_held_ch", 32'(evt_ch), 32'd0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("flush_pulse_end", 32'(err_flush), 32'd0);
      check_val("flush_ovf", 32'(overflow), 32'd0);
      evt_ready = 1'b1;
      step(4'b0000, 1'b0, 1'b0);
      check_val("flush_done_valid", 32'(evt_valid), 32'd0);
      check_val("flush_deliv", 32'(delivered_cnt), 32'd1);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("flush_stays_idle", 32'(evt_valid), 32'd0);

      // Grant and match on channel 3 in the same cycle
      do_reset();
      evt_ready = 1'b1;
      step(4'b1000, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      check_val("coll_first_valid", 32'(evt_valid), 32'd1);
      check_val("coll_first_ch", 32'(evt_ch), 32'd3);
      step(4'b0000, 1'b0, 1'b0);
      check_val("coll_second_valid", 32'(evt_valid), 32'd1);
      check_val("coll_second_ch", 32'(evt_ch), 32'd3);
      step(4'b0000, 1'b0, 1'b0);
      check_val("coll_idle", 32'(evt_valid), 32'd0);
      check_val("coll_deliv", 32'(delivered_cnt), 32'd2);

      // frame_done alone is harmless; then reset mid-stream
      evt_ready = 1'b0;
      step(4'b1111, 1'b1, 1'b0);
      check_val("fd_only_flush", 32'(err_flush), 32'd0);
      step(4'b0000, 1'b0, 1'b0);
      check_val("mid_valid", 32'(evt_valid), 32'd1);
      check_val("mid_ch", 32'(evt_ch), 32'd0);
      rst = 1'b1;
      step(4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      check_val("mrst_valid", 32'(evt_valid), 32'd0);
      check_val("mrst_ch", 32'(evt_ch), 32'd0);
      check_val("mrst_deliv", 32'(delivered_cnt), 32'd0);
      check_val("mrst_ovf", 32'(overflow), 32'd0);
      evt_ready = 1'b1;
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
      check_val("mrst_no_events", 32'(evt_valid), 32'd0);
      check_val("mrst_deliv_after", 32'(delivered_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
